// File: rtl/fifo_pkg.sv
// fifo_pkg: shared occupancy encoding and output-buffer depth for the FWFT read stage
package fifo_pkg;
    localparam int DEPTH_OUT = 2;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;
endpackage

// File: rtl/fwft_buf.sv
// fwft_buf: two-entry head/tail register pair holding words already read from RAM
module fwft_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output occ_t                  occ
);
    logic [DATA_WIDTH-1:0] head, tail, head_nxt, tail_nxt;
    occ_t occ_nxt;
    always_ff @(posedge clock) begin
        if (reset) begin
            occ  <= EMPTY;
            head <= '0;
            tail <= '0;
        end else begin
            occ  <= occ_nxt;
            head <= head_nxt;
            tail <= tail_nxt;
        end
    end
    // push with pop on a single word replaces the head directly; on a full pair the tail shifts up
    always_comb begin
        occ_nxt  = occ;
        head_nxt = head;
        tail_nxt = tail;
        case (occ)
            EMPTY: begin
                head_nxt = push ? din : head;
                occ_nxt  = push ? ONE : EMPTY;
            end
            ONE: begin
                head_nxt = (push && pop) ? din : head;
                tail_nxt = (push && !pop) ? din : tail;
                occ_nxt  = (push && !pop) ? FULL : (!push && pop) ? EMPTY : ONE;
            end
            FULL: begin
                head_nxt = pop ? tail : head;
                tail_nxt = (pop && push) ? din : tail;
                occ_nxt  = (pop && !push) ? ONE : FULL;
            end
            default: occ_nxt = EMPTY;
        endcase
    end
    assign dout = head;
endmodule

// File: rtl/fifo_fwft.sv
// fifo_fwft: turns an empty/inc FIFO read port into a first-word-fall-through valid/ready stream
// Define FIFO_FWFT_LEVEL_EN to expose out_level (words owned by this stage, buffered plus in flight).
module fifo_fwft
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_OUT  = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  empty,
    output logic                  rd_inc,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
`ifdef FIFO_FWFT_LEVEL_EN
    ,
    output logic [1:0]            out_level
`endif
);
    if (DEPTH_OUT != fifo_pkg::DEPTH_OUT) begin : g_bad_depth
        $error("fifo_fwft: DEPTH_OUT must be 2");
    end
    occ_t occ;
    logic inflight, pop;
    logic [1:0] level, need;
    assign pop       = out_valid && out_ready;
    assign out_valid = occ != EMPTY;
    assign level     = occ + 2'(inflight);
    // fetch only if the word arriving next cycle is guaranteed a free slot
    assign need      = level - 2'(pop);
    assign rd_inc    = !reset && !empty && need <= 2'd1;
    always_ff @(posedge clock) begin
        inflight <= reset ? 1'b0 : rd_inc;
    end
    fwft_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clock (clock),
        .reset (reset),
        .push  (inflight),
        .pop   (pop),
        .din   (rd_data),
        .dout  (out_data),
        .occ   (occ)
    );
`ifdef FIFO_FWFT_LEVEL_EN
    assign out_level = level;
`endif
endmodule

// File: tb/tb_fifo_fwft.sv
// tb_fifo_fwft: random and directed stimulus against a word-count/order model of the FWFT stage
module tb_fifo_fwft;
    logic clock, reset, empty, rd_inc, out_valid, out_ready;
    logic [7:0] rd_data, out_data;
`ifdef FIFO_FWFT_LEVEL_EN
    logic [1:0] out_level;
`endif
    fifo_fwft #(.DATA_WIDTH(8), .DEPTH_OUT(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .empty     (empty),
        .rd_inc    (rd_inc),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef FIFO_FWFT_LEVEL_EN
        ,
        .out_level (out_level)
`endif
    );
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0, errors = 0;
    logic [7:0] src[$], expq[$];
    int cnt_fetch, cnt_pop, cyc, npops, first_pop, last_pop;
    logic last_acc, held, gap;
    logic [7:0] held_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic load(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            src.push_back(8'(base + i));
            expq.push_back(8'(base + i));
        end
    endtask

    // one clock cycle: predict from word counts, compare, advance the RAM model
    task automatic tick();
        int owned, avail;
        logic popn, acc;
        empty = (src.size() == 0) || gap;
        #1;
        owned = cnt_fetch - cnt_pop;
        avail = owned - int'(last_acc);
        popn  = out_valid && out_ready;
        chk("rd_inc", rd_inc, !empty && (owned - int'(popn)) <= 1);
        chk("out_valid", out_valid, avail > 0);
`ifdef FIFO_FWFT_LEVEL_EN
        chk("out_level", out_level, owned);
`endif
        if (held) chk("hold_data", out_data, held_data);
        if (popn) begin
            if (expq.size() == 0) chk("extra_word", out_data, 32'hffff_ffff);
            else chk("order", out_data, expq.pop_front());
            npops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        acc       = rd_inc && !empty;
        held      = out_valid && !out_ready;
        held_data = out_data;
        @(posedge clock);
        #1;
        if (acc) begin
            rd_data = src.pop_front();
            cnt_fetch++;
        end
        if (popn) cnt_pop++;
        last_acc = acc;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        empty = 1'b0;
        src.delete();
        expq.delete();
        repeat (n) begin
            @(posedge clock);
            #1;
            chk("rst_rd_inc", rd_inc, 1'b0);
            chk("rst_valid", out_valid, 1'b0);
`ifdef FIFO_FWFT_LEVEL_EN
            chk("rst_level", out_level, 2'd0);
`endif
        end
        chk("rst_data", out_data, 8'h00);
        reset = 1'b0;
        empty = 1'b1;
        rd_data = 8'h00;
        cnt_fetch = 0;
        cnt_pop = 0;
        last_acc = 1'b0;
        held = 1'b0;
        cyc = 0;
    endtask

    initial begin
        reset = 1'b1; empty = 1'b1; out_ready = 1'b0; rd_data = 8'h00; gap = 1'b0;
        npops = 0; first_pop = -1; last_pop = -1;
        do_reset(2);
        repeat (10) tick();
        // single word: appears in cycle 3, visible in cycle 5, gone in 6
        out_ready = 1'b1;
        repeat (3) tick();
        load(8'hA5, 1);
        repeat (4) tick();
        chk("a5_drained", expq.size(), 0);
        // back-to-back stream
        npops = 0; first_pop = -1;
        load(0, 16);
        repeat (22) tick();
        chk("stream_count", npops, 16);
        chk("stream_gapless", last_pop - first_pop, 15);
        // backpressure: only two words may be pulled
        out_ready = 1'b0;
        load(1, 5);
        repeat (8) tick();
        chk("bp_src_left", src.size(), 3);
        chk("bp_head", out_data, 8'h01);
        out_ready = 1'b1;
        repeat (10) tick();
        chk("bp_drained", expq.size(), 0);
        // random ready and empty gaps
        load(8'h40, 200);
        for (int n = 0; n < 3000 && expq.size() > 0; n++) begin
            out_ready = 1'($urandom % 2);
            gap = ($urandom % 4) == 0;
            tick();
        end
        gap = 1'b0;
        chk("rand_drained", expq.size(), 0);
        // reset with a full buffer
        out_ready = 1'b0;
        load(8'h10, 6);
        repeat (5) tick();
        do_reset(1);
        out_ready = 1'b1;
        load(8'h80, 4);
        repeat (10) tick();
        chk("rst_full_drained", expq.size(), 0);
        // reset with a word in flight
        load(8'h20, 8);
        repeat (3) tick();
        do_reset(1);
        load(8'hC0, 4);
        repeat (10) tick();
        chk("rst_flight_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
